// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS32 memory stage.
//   state_e : memory-stage FSM states (StIdle, StAccess)
//   wb_t    : registered writeback bundle (valid, data, reg_write, write_reg)
//   WORD_W / REG_ADDR_W : datapath word and register-address widths
package mips_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [0:0] {
    StIdle,
    StAccess
  } state_e;

  typedef struct packed {
    logic                  valid;
    logic [WORD_W-1:0]     data;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] write_reg;
  } wb_t;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Bus access timeout counter.
//   clk, reset : clock and synchronous active-high reset
//   clear      : zero the count (asserted when an access is launched)
//   enable     : count one bus cycle (asserted while the access is outstanding)
//   expired    : high during the TIMEOUT-th enabled cycle since the last clear
// TIMEOUT = 0 disables the timeout; expired then never asserts.
module bus_timeout_ctr #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] Last = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // The count equals the number of completed enabled cycles, so the cycle that
  // sees cnt_q == TIMEOUT-1 is the TIMEOUT-th one.
  assign expired = (TIMEOUT != 0) && enable && (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != Last)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS32 memory stage: runs a req/ack data-bus transaction for lw/sw, stalls EX
// until the bus responds (or times out) and delivers a registered writeback bundle.
//   Parameter TIMEOUT : bus cycles per access before abort, 0 disables.
//   EX side  : in_valid, alu_result, write_data, mem_read, mem_write, mem_to_reg,
//              reg_write_in, write_reg_in in; stall out.
//   Bus side : bus_req, bus_we, bus_addr, bus_wdata out; bus_ack, bus_rdata in.
//   WB side  : wb_valid, wb_data, wb_reg_write, wb_write_reg out.
//   Errors   : bus_err (timeout pulse), align_err (misaligned pulse).
// Optional macro MEM_ALIGN_CHECK_EN: reject misaligned accesses without a bus
// cycle; otherwise the low address bits are dropped and align_err stays 0.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [WORD_W-1:0]     alu_result,
  input  logic [WORD_W-1:0]     write_data,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  mem_to_reg,
  input  logic                  reg_write_in,
  input  logic [REG_ADDR_W-1:0] write_reg_in,
  output logic                  stall,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [WORD_W-1:0]     bus_addr,
  output logic [WORD_W-1:0]     bus_wdata,
  input  logic                  bus_ack,
  input  logic [WORD_W-1:0]     bus_rdata,
  output logic                  wb_valid,
  output logic [WORD_W-1:0]     wb_data,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_write_reg,
  output logic                  bus_err,
  output logic                  align_err
);

  state_e state_q, state_d;

  logic                  mem_op, misaligned, capture;
  logic                  ctr_clear, ctr_en, expired;
  wb_t                   wb_q, wb_d;
  logic                  bus_err_q, bus_err_d;
  logic                  align_err_q, align_err_d;
  logic [WORD_W-1:0]     addr_q, wdata_q;
  logic                  we_q, mem_to_reg_q, reg_write_q;
  logic [REG_ADDR_W-1:0] write_reg_q;

  assign mem_op = mem_read | mem_write;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = |alu_result[1:0];
`else
  assign misaligned = 1'b0;
`endif

  bus_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (ctr_clear),
    .enable  (ctr_en),
    .expired (expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an ack in the expiry cycle wins, as both leave ACCESS.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && mem_op && !misaligned) state_d = StAccess;
      end
      StAccess: begin
        if (bus_ack || expired) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output and writeback-next logic
  always_comb begin
    stall       = 1'b0;
    bus_req     = 1'b0;
    capture     = 1'b0;
    ctr_clear   = 1'b0;
    ctr_en      = 1'b0;
    wb_d        = '0;
    bus_err_d   = 1'b0;
    align_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (!mem_op) begin
            wb_d.valid     = 1'b1;
            wb_d.data      = alu_result;
            wb_d.reg_write = reg_write_in;
            wb_d.write_reg = write_reg_in;
          end else if (misaligned) begin
            // Rejected access completes as a non-writing instruction.
            wb_d.valid     = 1'b1;
            wb_d.data      = alu_result;
            wb_d.write_reg = write_reg_in;
            align_err_d    = 1'b1;
          end else begin
            stall     = 1'b1;
            capture   = 1'b1;
            ctr_clear = 1'b1;
          end
        end
      end
      StAccess: begin
        bus_req = 1'b1;
        ctr_en  = 1'b1;
        stall   = !bus_ack;
        if (bus_ack) begin
          wb_d.valid     = 1'b1;
          wb_d.data      = mem_to_reg_q ? bus_rdata : addr_q;
          // Stores never write the register file.
          wb_d.reg_write = reg_write_q & ~we_q;
          wb_d.write_reg = write_reg_q;
        end else if (expired) begin
          // Faulting access retires without a register write.
          wb_d.valid     = 1'b1;
          wb_d.data      = addr_q;
          wb_d.write_reg = write_reg_q;
          bus_err_d      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_q         <= '0;
      bus_err_q    <= 1'b0;
      align_err_q  <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
    end else begin
      wb_q        <= wb_d;
      bus_err_q   <= bus_err_d;
      align_err_q <= align_err_d;
      if (capture) begin
        addr_q       <= {alu_result[WORD_W-1:2], 2'b00};
        wdata_q      <= write_data;
        we_q         <= mem_write;  // both read and write set means write
        mem_to_reg_q <= mem_to_reg;
        reg_write_q  <= reg_write_in;
        write_reg_q  <= write_reg_in;
      end
    end
  end

  assign bus_we       = we_q;
  assign bus_addr     = addr_q;
  assign bus_wdata    = wdata_q;
  assign wb_valid     = wb_q.valid;
  assign wb_data      = wb_q.data;
  assign wb_reg_write = wb_q.reg_write;
  assign wb_write_reg = wb_q.write_reg;
  assign bus_err      = bus_err_q;
  assign align_err    = align_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (TIMEOUT = 4).
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] alu_result, write_data;
  logic        mem_read, mem_write, mem_to_reg, reg_write_in;
  logic [4:0]  write_reg_in;
  logic        stall, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        wb_valid, wb_reg_write;
  logic [31:0] wb_data;
  logic [4:0]  wb_write_reg;
  logic        bus_err, align_err;

  int n_cmp = 0;
  int n_err = 0;
  int stall_cnt, req_cnt, err_cnt;

  mem_access_stage #(
    .TIMEOUT (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .alu_result   (alu_result),
    .write_data   (write_data),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_to_reg   (mem_to_reg),
    .reg_write_in (reg_write_in),
    .write_reg_in (write_reg_in),
    .stall        (stall),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata),
    .wb_valid     (wb_valid),
    .wb_data      (wb_data),
    .wb_reg_write (wb_reg_write),
    .wb_write_reg (wb_write_reg),
    .bus_err      (bus_err),
    .align_err    (align_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are sampled at +3.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    in_valid     = 1'b0;
    alu_result   = '0;
    write_data   = '0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write_in = 1'b0;
    write_reg_in = '0;
  endtask

  task automatic issue(input logic [31:0] alu, input logic [31:0] wd, input logic rd,
                       input logic wr, input logic m2r, input logic rw, input logic [4:0] rg);
    in_valid     = 1'b1;
    alu_result   = alu;
    write_data   = wd;
    mem_read     = rd;
    mem_write    = wr;
    mem_to_reg   = m2r;
    reg_write_in = rw;
    write_reg_in = rg;
  endtask

  initial begin
    reset     = 1'b1;
    bus_ack   = 1'b0;
    bus_rdata = '0;
    idle_inputs();
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check_eq("rst_wb_valid", wb_valid, 0);
    check_eq("rst_wb_data", wb_data, 0);
    check_eq("rst_bus_req", bus_req, 0);
    check_eq("rst_stall", stall, 0);
    check_eq("rst_bus_err", bus_err, 0);
    check_eq("rst_align_err", align_err, 0);
    tick();

    // ALU pass-through
    issue(32'h2A, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5);
    #1;
    check_eq("alu_stall_c0", stall, 0);
    tick();
    idle_inputs();
    #1;
    check_eq("alu_wb_valid", wb_valid, 1);
    check_eq("alu_wb_data", wb_data, 32'h2A);
    check_eq("alu_wb_reg", wb_write_reg, 5);
    check_eq("alu_wb_we", wb_reg_write, 1);
    check_eq("alu_stall_c1", stall, 0);
    tick();
    check_eq("alu_wb_pulse", wb_valid, 0);

    // lw at 0x100, ack in the 4th ACCESS cycle (same cycle the timeout expires)
    issue(32'h100, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8);
    #1;
    stall_cnt = 0;
    if (stall) stall_cnt++;
    check_eq("lw_c0_req", bus_req, 0);
    tick();
    idle_inputs();
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) begin
        bus_ack   = 1'b1;
        bus_rdata = 32'hDEADBEEF;
      end
      #1;
      if (stall) stall_cnt++;
      check_eq("lw_req", bus_req, 1);
      check_eq("lw_addr", bus_addr, 32'h100);
      check_eq("lw_we", bus_we, 0);
      tick();
    end
    bus_ack   = 1'b0;
    bus_rdata = '0;
    #1;
    check_eq("lw_stall_cycles", stall_cnt, 4);
    check_eq("lw_wb_valid", wb_valid, 1);
    check_eq("lw_wb_data", wb_data, 32'hDEADBEEF);
    check_eq("lw_wb_we", wb_reg_write, 1);
    check_eq("lw_wb_reg", wb_write_reg, 8);
    check_eq("lw_bus_err", bus_err, 0);
    check_eq("lw_req_drop", bus_req, 0);
    tick();

    // sw at 0x204, zero-wait ack
    issue(32'h204, 32'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    #1;
    check_eq("sw_stall_c0", stall, 1);
    tick();
    idle_inputs();
    bus_ack = 1'b1;
    #1;
    check_eq("sw_req", bus_req, 1);
    check_eq("sw_we", bus_we, 1);
    check_eq("sw_wdata", bus_wdata, 32'h1234);
    check_eq("sw_addr", bus_addr, 32'h204);
    check_eq("sw_stall_c1", stall, 0);
    tick();
    bus_ack = 1'b0;
    #1;
    check_eq("sw_wb_valid", wb_valid, 1);
    check_eq("sw_wb_we", wb_reg_write, 0);
    check_eq("sw_wb_data", wb_data, 32'h204);
    tick();

    // mem_read and mem_write both set: a write, and never a register write
    issue(32'h308, 32'hCAFE, 1'b1, 1'b1, 1'b1, 1'b1, 5'd9);
    tick();
    idle_inputs();
    bus_ack   = 1'b1;
    bus_rdata = 32'h5555;
    #1;
    check_eq("rw_we", bus_we, 1);
    check_eq("rw_wdata", bus_wdata, 32'hCAFE);
    tick();
    bus_ack   = 1'b0;
    bus_rdata = '0;
    check_eq("rw_wb_we", wb_reg_write, 0);
    tick();

    // Timeout: lw with no ack
    issue(32'h300, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7);
    tick();
    idle_inputs();
    req_cnt = 0;
    err_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus_req) req_cnt++;
      if (bus_err) begin
        err_cnt++;
        check_eq("to_wb_valid", wb_valid, 1);
        check_eq("to_wb_we", wb_reg_write, 0);
      end
      tick();
    end
    check_eq("to_req_cycles", req_cnt, 4);
    check_eq("to_err_pulses", err_cnt, 1);
    issue(32'h55, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3);
    tick();
    idle_inputs();
    check_eq("to_add_valid", wb_valid, 1);
    check_eq("to_add_data", wb_data, 32'h55);
    check_eq("to_add_we", wb_reg_write, 1);
    tick();

    // Reset during ACCESS cycle 2 of a lw
    issue(32'h400, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4);
    tick();
    idle_inputs();
    tick();
    #1;
    check_eq("rm_req_before", bus_req, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_eq("rm_req", bus_req, 0);
    check_eq("rm_stall", stall, 0);
    check_eq("rm_wb_valid", wb_valid, 0);
    bus_ack   = 1'b1;
    bus_rdata = 32'hBAD0BAD0;
    tick();
    check_eq("rm_late_wb", wb_valid, 0);
    check_eq("rm_late_err", bus_err, 0);
    bus_ack   = 1'b0;
    bus_rdata = '0;
    tick();

    // lw at misaligned 0x102
    issue(32'h102, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6);
`ifdef MEM_ALIGN_CHECK_EN
    #1;
    check_eq("al_stall", stall, 0);
    tick();
    idle_inputs();
    #1;
    check_eq("al_req", bus_req, 0);
    check_eq("al_err", align_err, 1);
    check_eq("al_wb_valid", wb_valid, 1);
    check_eq("al_wb_we", wb_reg_write, 0);
    tick();
    check_eq("al_err_pulse", align_err, 0);
`else
    tick();
    idle_inputs();
    bus_ack   = 1'b1;
    bus_rdata = 32'h77;
    #1;
    check_eq("al_req", bus_req, 1);
    check_eq("al_addr", bus_addr, 32'h100);
    tick();
    bus_ack   = 1'b0;
    bus_rdata = '0;
    check_eq("al_wb_valid", wb_valid, 1);
    check_eq("al_wb_data", wb_data, 32'h77);
    check_eq("al_err", align_err, 0);
`endif
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory stage of the MIPS32 datapath, directly downstream of the ALU. It takes the ALU result as a load/store address (or as a plain result), runs a req/ack transaction on the data bus for lw/sw, and stalls the pipeline until the bus responds. It delivers a registered writeback bundle to the register file.

## Interface
- `TIMEOUT`, default 64: bus cycles allowed per access before abort; 0 disables the timeout.
- `clk`  in  1  clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  instruction present from EX.
- `alu_result`  in  32  ALU output: address for lw/sw, result otherwise.
- `write_data`  in  32  rt value for sw.
- `mem_read`  in  1  lw.
- `mem_write`  in  1  sw.
- `mem_to_reg`  in  1  writeback selects load data.
- `reg_write_in`  in  1  instruction writes a register.
- `write_reg_in`  in  5  destination register.
- `stall`  out  1  EX must hold all inputs stable.
- `bus_req`  out  1  access request.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  32  word address, bits [1:0] = 0.
- `bus_wdata`  out  32  store data.
- `bus_ack`  in  1  access complete; sampled only while `bus_req` = 1.
- `bus_rdata`  in  32  load data, valid with `bus_ack`.
- `wb_valid`  out  1  writeback bundle valid.
- `wb_data`  out  32  writeback value.
- `wb_reg_write`  out  1  register-file write enable.
- `wb_write_reg`  out  5  destination register.
- `bus_err`  out  1  one-cycle pulse on timeout.
- `align_err`  out  1  one-cycle pulse on a misaligned access.

## Operation
- FSM states are IDLE and ACCESS.
- **IDLE**
  - A non-memory instruction (`in_valid`, no `mem_read`/`mem_write`) is registered to the wb outputs at the next edge with `wb_data` = `alu_result`. No stall.
  - A memory instruction asserts `stall` combinationally and captures address, data, `we` and the wb control fields. The FSM then moves to ACCESS.
  - If `mem_read` and `mem_write` are both set, the access is a write.
- **ACCESS**
  - `bus_req` = 1. `bus_addr`, `bus_we` and `bus_wdata` are driven from the captured registers and held constant.
  - `stall` = !`bus_ack`.
  - On `bus_ack`, the next edge loads the wb outputs and returns the FSM to IDLE.
  - `wb_data` = `bus_rdata` if `mem_to_reg`, else the captured address.
  - A store delivers `wb_valid` = 1 with `wb_reg_write` = 0.
- **Timeout**
  - The counter clears on entering ACCESS.
  - When it reaches `TIMEOUT` without an ack: `bus_req` drops, `bus_err` pulses, and the FSM returns to IDLE.
  - `wb_valid` = 1 with `wb_reg_write` = 0, so the faulting load is not written back.
- **`wb_valid`** is a one-cycle pulse per accepted instruction. It is 0 when `in_valid` = 0 in IDLE.
- **Reset values:** all outputs are 0 and the state is IDLE.
- **Reset mid-access:** `bus_req` drops at the reset edge and the transaction is abandoned. No wb, `bus_err` or `align_err` pulse is produced.

## Timing
- Non-memory instruction: latency 1.
- Memory instruction: latency 2 with zero-wait ack, i.e. capture in cycle 0, req+ack in cycle 1, `wb_valid` in cycle 2.
  - Each ack wait-cycle adds 1.
  - `stall` is high in cycle 0 and in every ACCESS cycle without ack.
- The next instruction is accepted in IDLE in the cycle after the ack cycle. There is no back-to-back bus access without one IDLE cycle.
- An ack on the same cycle the counter reaches `TIMEOUT` is treated as success.
- `bus_ack` while `bus_req` = 0 is ignored.

## Configuration
- **`MEM_ALIGN_CHECK_EN` defined:**
  - A memory instruction with `alu_result[1:0]` ≠ 0 issues no bus access and asserts no stall.
  - After 1 cycle it produces `align_err` pulse, `wb_valid` = 1 and `wb_reg_write` = 0.
- **`MEM_ALIGN_CHECK_EN` undefined:**
  - Address bits [1:0] are ignored and the access proceeds to the word address.
  - `align_err` is tied 0.
  - The port exists in both builds.

## Structure
- **Shared package `mips_pkg`:**
  - state enum (IDLE, ACCESS);
  - the writeback bundle typedef (valid, data, reg_write, write_reg);
  - the `WORD_W` = 32 and `REG_ADDR_W` = 5 constants.
- **Sub-module `bus_timeout_ctr`:** clear, enable and `TIMEOUT` parameter inputs; outputs an expired flag. Instantiated once.

## Test plan
- **ALU pass-through:** `in_valid`, `alu_result` = 0x0000_002A, `reg_write_in` = 1, `write_reg_in` = 5.
  - Next cycle: `wb_valid` = 1, `wb_data` = 0x2A, `wb_write_reg` = 5.
  - `stall` = 0 throughout.
- **lw with 3 wait cycles:** `alu_result` = 0x100, ack in the 4th ACCESS cycle with `bus_rdata` = 0xDEAD_BEEF.
  - `bus_addr` = 0x100 and `bus_we` = 0.
  - `stall` is high 4 cycles.
  - `wb_data` = 0xDEAD_BEEF at cycle 5.
- **sw with zero-wait ack:** `alu_result` = 0x204, `write_data` = 0x1234.
  - Cycle 1: `bus_we` = 1, `bus_wdata` = 0x1234.
  - Cycle 2: `wb_valid` = 1, `wb_reg_write` = 0.
- **Timeout:** `TIMEOUT` = 4, lw, no ack.
  - `bus_req` is high exactly 4 cycles.
  - `bus_err` pulses once and `wb_reg_write` = 0.
  - A following add passes through normally.
- **Reset in ACCESS cycle 2 of a lw:**
  - Next cycle: `bus_req` = 0, `stall` = 0, `wb_valid` = 0.
  - A late ack is ignored.
- **`MEM_ALIGN_CHECK_EN` build:** lw at 0x102.
  - No `bus_req`.
  - `align_err` pulses 1 cycle and `wb_reg_write` = 0.
  - In a build without the macro, the same stimulus gives `bus_addr` = 0x100.
